// File: rtl/psum_acc_sequencer_pkg.sv
// Shared definitions for the psum accumulation sequencer: inst field map,
// FSM encoding and width helpers.
package psum_acc_sequencer_pkg;

  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_APMEM_HI = 30;
  localparam int INST_APMEM_LO = 20;

  localparam int ADDR_BW_DEF = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  // Counter width that stays legal for a range of one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_acc_sequencer_onij_addr_gen.sv
// Pixel (ox/oy) and kernel-offset (ki/kj) counters with an incrementally
// maintained pmem read address; no multipliers anywhere.
module psum_acc_sequencer_onij_addr_gen
  import psum_acc_sequencer_pkg::*;
#(
  parameter int OUT_W     = 4,
  parameter int OUT_H     = 4,
  parameter int K         = 3,
  parameter int LEN_NIJ   = 36,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_BW   = ADDR_BW_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clr_i,
  input  logic                        step_i,
  input  logic                        next_pix_i,
  output logic [ADDR_BW-1:0]          addr_o,
  output logic                        kij_zero_o,
  output logic                        last_pix_o,
  output logic [cw(OUT_W*OUT_H)-1:0]  pix_idx_o
);

  localparam int KW = cw(K);
  localparam int XW = cw(OUT_W);
  localparam int YW = cw(OUT_H);
  localparam int IW = cw(OUT_W*OUT_H);

  localparam logic [KW-1:0]      K_MAX  = KW'(K-1);
  localparam logic [XW-1:0]      X_MAX  = XW'(OUT_W-1);
  localparam logic [YW-1:0]      Y_MAX  = YW'(OUT_H-1);
  localparam logic [ADDR_BW-1:0] ROW_A  = ADDR_BW'(OUT_W+K-1);
  localparam logic [ADDR_BW-1:0] LEN_A  = ADDR_BW'(LEN_NIJ);
  localparam logic [ADDR_BW-1:0] K_A    = ADDR_BW'(K);
  localparam logic [ADDR_BW-1:0] BASE_A = ADDR_BW'(BASE_ADDR);

  logic [KW-1:0]      kj_q, kj_d, ki_q, ki_d;
  logic [XW-1:0]      ox_q, ox_d;
  logic [YW-1:0]      oy_q, oy_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [ADDR_BW-1:0] sec_q, sec_d;   // kij*LEN_NIJ
  logic [ADDR_BW-1:0] row_q, row_d;   // ki*(OUT_W+K-1)
  logic [ADDR_BW-1:0] pix_q, pix_d;   // oy*(OUT_W+K-1)+ox

  always_comb begin
    kj_d  = kj_q;
    ki_d  = ki_q;
    ox_d  = ox_q;
    oy_d  = oy_q;
    idx_d = idx_q;
    sec_d = sec_q;
    row_d = row_q;
    pix_d = pix_q;
    if (clr_i) begin
      kj_d  = '0;
      ki_d  = '0;
      ox_d  = '0;
      oy_d  = '0;
      idx_d = '0;
      sec_d = '0;
      row_d = '0;
      pix_d = '0;
    end else begin
      if (step_i) begin
        if (kj_q == K_MAX) begin
          kj_d = '0;
          if (ki_q == K_MAX) begin
            ki_d  = '0;
            row_d = '0;
            sec_d = '0;
          end else begin
            ki_d  = ki_q + 1'b1;
            row_d = row_q + ROW_A;
            sec_d = sec_q + LEN_A;
          end
        end else begin
          kj_d  = kj_q + 1'b1;
          sec_d = sec_q + LEN_A;
        end
      end
      if (next_pix_i) begin
        idx_d = last_pix_o ? '0 : idx_q + 1'b1;
        if (ox_q == X_MAX) begin
          ox_d = '0;
          // Jumping from the last column to the next row start skips K-1 halo columns.
          if (oy_q == Y_MAX) begin
            oy_d  = '0;
            pix_d = '0;
          end else begin
            oy_d  = oy_q + 1'b1;
            pix_d = pix_q + K_A;
          end
        end else begin
          ox_d  = ox_q + 1'b1;
          pix_d = pix_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kj_q  <= '0;
      ki_q  <= '0;
      ox_q  <= '0;
      oy_q  <= '0;
      idx_q <= '0;
      sec_q <= '0;
      row_q <= '0;
      pix_q <= '0;
    end else begin
      kj_q  <= kj_d;
      ki_q  <= ki_d;
      ox_q  <= ox_d;
      oy_q  <= oy_d;
      idx_q <= idx_d;
      sec_q <= sec_d;
      row_q <= row_d;
      pix_q <= pix_d;
    end
  end

  assign addr_o     = BASE_A + sec_q + row_q + pix_q + ADDR_BW'(kj_q);
  assign kij_zero_o = (kj_q == '0) && (ki_q == '0);
  assign last_pix_o = (ox_q == X_MAX) && (oy_q == Y_MAX);
  assign pix_idx_o  = idx_q;

endmodule

// File: rtl/psum_acc_sequencer.sv
// Walks every output pixel, reads its K*K psums from pmem and drives the
// SFP accumulator acc/clear/valid controls. All outputs are registered.
module psum_acc_sequencer
  import psum_acc_sequencer_pkg::*;
#(
  parameter int OUT_W     = 4,
  parameter int OUT_H     = 4,
  parameter int K         = 3,
  parameter int LEN_NIJ   = 36,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_BW   = ADDR_BW_DEF
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       cen_pmem_o,
  output logic                       wen_pmem_o,
  output logic [ADDR_BW-1:0]         a_pmem_o,
  output logic                       acc_o,
  output logic                       sfp_clr_o,
  output logic                       out_valid_o,
  output logic [cw(OUT_W*OUT_H)-1:0] out_idx_o
);

  localparam int IW = cw(OUT_W*OUT_H);

  if (BASE_ADDR + K*K*LEN_NIJ - 1 >= (1 << ADDR_BW)) begin : g_addr_overflow
    $error("psum_acc_sequencer: ADDR_BW too narrow for BASE_ADDR+K*K*LEN_NIJ-1");
  end

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, cen_q, cen_d;
  logic               acc_q, acc_d, clr_q, clr_d, ov_q, ov_d;
  logic [ADDR_BW-1:0] a_q, a_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic               gen_clr, gen_step, gen_next_pix;
  logic [ADDR_BW-1:0] gen_addr;
  logic               gen_kij_zero, gen_last_pix;
  logic [IW-1:0]      gen_pix_idx;

  // The generator runs one kij ahead of the address on the bus: it is stepped
  // in CLR and in every READ but the last, so it has wrapped back to kij=0
  // exactly when the final read of the pixel is being presented.
  assign gen_clr      = (state_q == S_IDLE);
  assign gen_step     = (state_q == S_CLR) || ((state_q == S_READ) && !gen_kij_zero);
  assign gen_next_pix = (state_q == S_OUT);

  psum_acc_sequencer_onij_addr_gen #(
    .OUT_W    (OUT_W),
    .OUT_H    (OUT_H),
    .K        (K),
    .LEN_NIJ  (LEN_NIJ),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_BW  (ADDR_BW)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (gen_clr),
    .step_i    (gen_step),
    .next_pix_i(gen_next_pix),
    .addr_o    (gen_addr),
    .kij_zero_o(gen_kij_zero),
    .last_pix_o(gen_last_pix),
    .pix_idx_o (gen_pix_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CLR;
      S_CLR:   state_d = S_READ;
      S_READ:  if (gen_kij_zero) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   state_d = gen_last_pix ? S_FIN : S_CLR;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    clr_d  = (state_d == S_CLR);
    cen_d  = (state_d != S_READ);
    acc_d  = ((state_d == S_READ) && (state_q == S_READ)) || (state_d == S_DRAIN);
    ov_d   = (state_d == S_OUT);
    a_d    = (state_d == S_READ) ? gen_addr : a_q;
    idx_d  = (state_d == S_OUT) ? gen_pix_idx : idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cen_q  <= 1'b1;
      acc_q  <= 1'b0;
      clr_q  <= 1'b0;
      ov_q   <= 1'b0;
      a_q    <= '0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cen_q  <= cen_d;
      acc_q  <= acc_d;
      clr_q  <= clr_d;
      ov_q   <= ov_d;
      a_q    <= a_d;
      idx_q  <= idx_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cen_pmem_o  = cen_q;
  assign wen_pmem_o  = 1'b1;
  assign a_pmem_o    = a_q;
  assign acc_o       = acc_q;
  assign sfp_clr_o   = clr_q;
  assign out_valid_o = ov_q;
  assign out_idx_o   = idx_q;

endmodule

// File: tb/tb_psum_acc_sequencer.sv
// Scoreboard bench: expected reads/pixels are queued when a sweep is started
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_psum_acc_sequencer;

  localparam int OW = 4, OH = 4, KK = 3, LEN = 36, BASE = 0, ABW = 11;
  localparam int NPIX = OW*OH;
  localparam int NRD  = NPIX*KK*KK;
  localparam int PIX_CYC = KK*KK + 3;   // CLR + K*K reads + DRAIN + OUT

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, cen, wen, acc, sclr, ov;
  logic [ABW-1:0] a;
  logic [3:0] idx;

  logic rst2, start2, busy2, done2, cen2, wen2, acc2, sclr2, ov2;
  logic [ABW-1:0] a2;
  logic [1:0] idx2;

  psum_acc_sequencer #(.OUT_W(OW), .OUT_H(OH), .K(KK), .LEN_NIJ(LEN), .BASE_ADDR(BASE), .ADDR_BW(ABW)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .cen_pmem_o(cen), .wen_pmem_o(wen), .a_pmem_o(a), .acc_o(acc),
    .sfp_clr_o(sclr), .out_valid_o(ov), .out_idx_o(idx));

  psum_acc_sequencer #(.OUT_W(2), .OUT_H(2), .K(3), .LEN_NIJ(16), .BASE_ADDR(0), .ADDR_BW(ABW)) dut2 (
    .clk_i(clk), .reset_i(rst2), .start_i(start2), .busy_o(busy2), .done_o(done2),
    .cen_pmem_o(cen2), .wen_pmem_o(wen2), .a_pmem_o(a2), .acc_o(acc2),
    .sfp_clr_o(sclr2), .out_valid_o(ov2), .out_idx_o(idx2));

  int n_tests = 0, n_fail = 0;
  int exp_addr[$], exp_idx[$], rd_log[$];
  int done_seen = 0, ov_cnt = 0, busy_cnt = 0, acc_cnt = 0;
  bit prev_rd = 0, prev_acc = 0, prev_ov = 0;
  int rd2[$], ov2_log[$];
  int done2_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Address of psum for pixel p, kernel offset kij, straight from the sweep rules.
  function automatic int ref_addr(input int ow, input int k, input int len, input int base,
                                  input int p, input int kij);
    int ox, oy;
    ox = p % ow;
    oy = p / ow;
    return base + kij*len + (oy + kij/k)*(ow + k - 1) + ox + kij%k;
  endfunction

  task automatic push_sweep();
    for (int p = 0; p < NPIX; p++) begin
      for (int kij = 0; kij < KK*KK; kij++) exp_addr.push_back(ref_addr(OW, KK, LEN, BASE, p, kij));
      exp_idx.push_back(p);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) check("acc_one_after_read", acc, prev_rd);
    else               check("acc_when_idle", acc, 0);
    if (cen === 1'b0) begin
      rd_log.push_back(int'(a));
      if (exp_addr.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: got addr %0d, required no read", a);
      end else check("read_addr", a, exp_addr.pop_front());
    end
    if (sclr === 1'b1) acc_cnt = 0;
    if (acc === 1'b1) acc_cnt++;
    if (ov === 1'b1) begin
      ov_cnt++;
      check("acc_cycles_per_pixel", acc_cnt, KK*KK);
      check("out_valid_after_last_acc", prev_acc, 1);
      if (exp_idx.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out_valid: got idx %0d, required none", idx);
      end else check("out_idx", idx, exp_idx.pop_front());
    end
    if (done === 1'b1) begin
      done_seen++;
      check("busy_cycles_before_done", busy_cnt, NPIX*PIX_CYC);
      check("done_after_last_out_valid", prev_ov, 1);
      check("reads_outstanding_at_done", exp_addr.size(), 0);
      check("wen_const", wen, 1);
    end
    if (busy === 1'b1 && done !== 1'b1) busy_cnt++;
    else if (busy !== 1'b1)             busy_cnt = 0;
    prev_rd  = (cen === 1'b0);
    prev_acc = (acc === 1'b1);
    prev_ov  = (ov === 1'b1);
  end

  always @(negedge clk) begin
    if (cen2 === 1'b0) rd2.push_back(int'(a2));
    if (ov2 === 1'b1)  ov2_log.push_back(int'(idx2));
    if (done2 === 1'b1) done2_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input bit spur);
    int d0, o0, cyc;
    d0 = done_seen;
    o0 = ov_cnt;
    cyc = 0;
    rd_log.delete();
    push_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done_seen == d0 && cyc < 400) begin
      cyc++;
      // Extra start pulses mid-sweep must be ignored.
      start = spur && (cyc == 50 || $urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b0;
    check("sweep_done_pulses", done_seen - d0, 1);
    check("sweep_out_valids", ov_cnt - o0, NPIX);
    check("sweep_reads", rd_log.size(), NRD);
    if (rd_log.size() == NRD) check("pix15_last_addr", rd_log[NRD-1], 323);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cen"}, cen, 1);
    check({tag, "_wen"}, wen, 1);
    check({tag, "_a_pmem"}, a, 0);
    check({tag, "_acc"}, acc, 0);
    check({tag, "_sfp_clr"}, sclr, 0);
    check({tag, "_out_valid"}, ov, 0);
    check({tag, "_out_idx"}, idx, 0);
  endtask

  initial begin
    int pix0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    int d0, o0, cyc, n;

    rst = 1'b1; start = 1'b0; rst2 = 1'b1; start2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0; rst2 = 1'b0;
    repeat (10) tick();
    check_reset_outputs("idle");

    run_sweep(1'b0);
    for (int i = 0; i < 9; i++)
      if (rd_log.size() > i) check("pix0_addr", rd_log[i], pix0[i]);

    for (int s = 0; s < 2; s++) begin
      n = $urandom_range(1, 10);
      repeat (n) tick();
      run_sweep(1'b1);
    end

    // Reset while reading pixel 5.
    tick();
    d0 = done_seen; o0 = ov_cnt; cyc = 0;
    push_sweep();
    start = 1'b1; tick(); start = 1'b0;
    while (!((ov_cnt - o0) == 5 && cen === 1'b0) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reached_pixel5_read", ov_cnt - o0, 5);
    n = $urandom_range(0, 7);
    repeat (n) tick();
    check("reset_point_in_read", cen, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr.delete();
    exp_idx.delete();
    check_reset_outputs("midreset");
    repeat (20) tick();
    check("no_done_after_reset", done_seen - d0, 0);
    run_sweep(1'b0);
    if (rd_log.size() > 0) check("restart_first_addr", rd_log[0], 0);

    // Start coincident with reset is dropped.
    tick();
    o0 = ov_cnt;
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    repeat (3) tick();
    check("start_with_reset_busy", busy, 0);
    check("start_with_reset_cen", cen, 1);
    check("start_with_reset_no_out", ov_cnt - o0, 0);

    // Small-geometry instance: 2x2 outputs, LEN_NIJ=16.
    rd2.delete(); ov2_log.delete();
    d0 = done2_seen; cyc = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    while (done2_seen == d0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("p2_done", done2_seen - d0, 1);
    check("p2_reads", rd2.size(), 36);
    if (rd2.size() == 36) begin
      for (int p = 0; p < 4; p++)
        for (int kij = 0; kij < 9; kij++)
          check("p2_addr", rd2[p*9 + kij], ref_addr(2, 3, 16, 0, p, kij));
      check("p2_pix3_kij8_addr", rd2[35], 143);
    end
    check("p2_out_valids", ov2_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (ov2_log.size() > i) check("p2_out_idx", ov2_log[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
